// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - dual programmable-pattern serial detector
// Sticky or pulse flags, optional overlap, saturating match counter.
module seq_pattern_detector #(
  parameter int PW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          en,
  input  logic          x,
  input  logic [PW-1:0] pat_a,
  input  logic [PW-1:0] pat_b,
  input  logic          sticky,
  input  logic          overlap,
  output logic          za,
  output logic          zb,
  output logic          z,
  output logic [CW-1:0] match_cnt
);

  localparam int            FW        = $clog2(PW + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PW);

  logic [PW-1:0] hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d, fill_nx;
  logic          za_q, za_d;
  logic          zb_q, zb_d;
  logic          z_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ma, mb;

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    fill_nx = fill_q;
    ma      = 1'b0;
    mb      = 1'b0;
    if (en) begin
      hist_d  = {hist_q[PW-2:0], x};
      fill_nx = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      // fill gating keeps the all-zero reset history from ever matching
      ma      = (fill_nx == FILL_FULL) && (hist_d == pat_a);
      mb      = (fill_nx == FILL_FULL) && (hist_d == pat_b);
      fill_d  = (!overlap && (ma || mb)) ? '0 : fill_nx;
    end
    za_d  = sticky ? (za_q | ma) : ma;
    zb_d  = sticky ? (zb_q | mb) : mb;
    cnt_d = cnt_q;
    if ((ma || mb) && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      hist_q <= '0;
      fill_q <= '0;
      za_q   <= 1'b0;
      zb_q   <= 1'b0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      za_q   <= za_d;
      zb_q   <= zb_d;
      z_q    <= za_d | zb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign za        = za_q;
  assign zb        = zb_q;
  assign z         = z_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - bench for seq_pattern_detector
// Reference model feeds a scoreboard queue; directed checks cover the listed scenarios.
module tb_seq_pattern_detector;

  localparam int PW = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          init_n = 1'b0;
  logic          en = 1'b0;
  logic          x = 1'b0;
  logic [PW-1:0] pat_a = '0;
  logic [PW-1:0] pat_b = '0;
  logic          sticky = 1'b0;
  logic          overlap = 1'b1;
  logic          za, zb, z;
  logic [CW-1:0] match_cnt;

  typedef struct packed {
    logic          za;
    logic          zb;
    logic          z;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            failures = 0;

  logic [PW-1:0] m_hist = '0;
  int            m_fill = 0;
  logic          m_za = 1'b0;
  logic          m_zb = 1'b0;
  int            m_cnt = 0;

  seq_pattern_detector #(.PW(PW), .CW(CW)) dut (
    .clk       (clk),
    .init_n    (init_n),
    .en        (en),
    .x         (x),
    .pat_a     (pat_a),
    .pat_b     (pat_b),
    .sticky    (sticky),
    .overlap   (overlap),
    .za        (za),
    .zb        (zb),
    .z         (z),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t ex;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    ex = sb.pop_front();
    chk({tag, "_za"}, {31'd0, za}, {31'd0, ex.za});
    chk({tag, "_zb"}, {31'd0, zb}, {31'd0, ex.zb});
    chk({tag, "_z"}, {31'd0, z}, {31'd0, ex.z});
    chk({tag, "_cnt"}, {30'd0, match_cnt}, {30'd0, ex.cnt});
  endtask

  task automatic do_reset();
    init_n = 1'b0;
    en = 1'b1;
    x = 1'b1;
    m_hist = '0;
    m_fill = 0;
    m_za = 1'b0;
    m_zb = 1'b0;
    m_cnt = 0;
    sb.push_back('{1'b0, 1'b0, 1'b0, CW'(0)});
    @(posedge clk);
    #1;
    pop_cmp("reset");
    init_n = 1'b1;
    en = 1'b0;
  endtask

  task automatic step(input logic e, input logic b, input string tag);
    logic [PW-1:0] nh;
    int            nf;
    logic          ma, mb;
    en = e;
    x = b;
    ma = 1'b0;
    mb = 1'b0;
    if (e) begin
      nh = {m_hist[PW-2:0], b};
      nf = (m_fill < PW) ? m_fill + 1 : PW;
      ma = (nf == PW) && (nh == pat_a);
      mb = (nf == PW) && (nh == pat_b);
      m_hist = nh;
      m_fill = (!overlap && (ma || mb)) ? 0 : nf;
    end
    m_za = sticky ? (m_za | ma) : ma;
    m_zb = sticky ? (m_zb | mb) : mb;
    if ((ma || mb) && m_cnt < CMAX) m_cnt++;
    sb.push_back('{m_za, m_zb, m_za | m_zb, CW'(m_cnt)});
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic send(input logic [15:0] bits, input int n, input string tag);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], tag);
  endtask

  initial begin
    // sticky detection
    do_reset();
    pat_a = 4'b0011; pat_b = 4'b1100; sticky = 1'b1; overlap = 1'b1;
    send(16'b001, 3, "stk");
    chk("stk_za_pre", {31'd0, za}, 32'd0);
    send(16'b1, 1, "stk");
    chk("stk_za_4", {31'd0, za}, 32'd1);
    send(16'b10, 2, "stk");
    chk("stk_za_hold", {31'd0, za}, 32'd1);
    chk("stk_zb_pre", {31'd0, zb}, 32'd0);
    send(16'b0, 1, "stk");
    chk("stk_zb_7", {31'd0, zb}, 32'd1);
    chk("stk_cnt", {30'd0, match_cnt}, 32'd2);
    sticky = 1'b0;
    step(1'b0, 1'b0, "stk_off");
    chk("stk_off_z", {31'd0, z}, 32'd0);

    // overlap on
    do_reset();
    pat_a = 4'b1010; pat_b = 4'b1111; sticky = 1'b0; overlap = 1'b1;
    send(16'b1010, 4, "ov1");
    chk("ov1_za_4", {31'd0, za}, 32'd1);
    send(16'b1, 1, "ov1");
    chk("ov1_za_5", {31'd0, za}, 32'd0);
    send(16'b0, 1, "ov1");
    chk("ov1_za_6", {31'd0, za}, 32'd1);
    chk("ov1_cnt", {30'd0, match_cnt}, 32'd2);

    // overlap off
    do_reset();
    overlap = 1'b0;
    send(16'b1010, 4, "ov0");
    chk("ov0_za_4", {31'd0, za}, 32'd1);
    send(16'b10, 2, "ov0");
    chk("ov0_za_6", {31'd0, za}, 32'd0);
    chk("ov0_cnt", {30'd0, match_cnt}, 32'd1);

    // en gaps
    do_reset();
    pat_a = 4'b0011; overlap = 1'b1;
    send(16'b00, 2, "gap");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], "gap_idle");
      chk("gap_za_idle", {31'd0, za}, 32'd0);
    end
    send(16'b1, 1, "gap");
    chk("gap_za_pre", {31'd0, za}, 32'd0);
    send(16'b1, 1, "gap");
    chk("gap_za_hit", {31'd0, za}, 32'd1);
    step(1'b0, 1'b0, "gap_after");
    chk("gap_za_after", {31'd0, za}, 32'd0);
    chk("gap_cnt", {30'd0, match_cnt}, 32'd1);

    // reset mid-sequence
    do_reset();
    send(16'b001, 3, "rst");
    do_reset();
    chk("rst_z", {31'd0, z}, 32'd0);
    send(16'b1, 1, "rst");
    chk("rst_za_nomatch", {31'd0, za}, 32'd0);
    send(16'b001, 3, "rst");
    chk("rst_za_partial", {31'd0, za}, 32'd0);
    send(16'b1, 1, "rst");
    chk("rst_za_hit", {31'd0, za}, 32'd1);

    // fill gating against the all-zero reset history
    do_reset();
    pat_a = 4'b0000; pat_b = 4'b1111;
    for (int i = 1; i <= 3; i++) begin
      send(16'b0, 1, "fill");
      chk("fill_za_early", {31'd0, za}, 32'd0);
    end
    send(16'b0, 1, "fill");
    chk("fill_za_4", {31'd0, za}, 32'd1);

    // identical patterns and counter saturation
    do_reset();
    pat_a = 4'b1111; pat_b = 4'b1111; overlap = 1'b1; sticky = 1'b0;
    send(16'b111, 3, "sat");
    chk("sat_cnt_pre", {30'd0, match_cnt}, 32'd0);
    for (int i = 4; i <= 8; i++) begin
      send(16'b1, 1, "sat");
      chk("sat_za", {31'd0, za}, 32'd1);
      chk("sat_zb", {31'd0, zb}, 32'd1);
      chk("sat_cnt", {30'd0, match_cnt}, (i - 3 > CMAX) ? CMAX : i - 3);
    end
    step(1'b0, 1'b0, "sat_idle");
    chk("sat_z_idle", {31'd0, z}, 32'd0);
    chk("sat_sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
